// File: rtl/axis_frame_arbiter_if.sv
// AXI-Stream bundle for the frame arbiter: N packed source lanes in,
// one tagged stream out toward the sampler.
interface axis_frame_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
);
  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic [ID_W-1:0]           m_axis_tid;
  logic                      m_axis_tlast;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  m_axis_tready,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tid,
    output m_axis_tlast
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    output m_axis_tready,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tid,
    input  m_axis_tlast
  );
endinterface

// File: rtl/axis_frame_arbiter.sv
// Round-robin frame arbiter: one source owns the sampler path for
// exactly FRAME_LEN handshaked beats, then one IDLE cycle re-arbitrates.
module axis_frame_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 8,
  parameter int ID_W      = 2
) (
  input  logic               clk,
  input  logic               reset,
  axis_frame_arbiter_if.slave bus,
  output logic [NUM_SRC-1:0] grant,
  output logic               busy
);
  localparam int CW = $clog2(FRAME_LEN);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    tid_q, tid_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               found;
  logic [ID_W-1:0]    sel;
  logic [DATA_W-1:0]  m_data;
  logic               m_valid;
  logic               m_last;
  logic [NUM_SRC-1:0] s_ready;
  logic               fire;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      tid_q   <= '0;
      last_q  <= ID_W'(NUM_SRC - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      tid_q   <= tid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scan above last_q first, then wrap so last_q is checked last.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && bus.s_axis_tvalid[i]
          && i > int'(last_q)) begin
        found = 1'b1;
        sel   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && bus.s_axis_tvalid[i]
          && i <= int'(last_q)) begin
        found = 1'b1;
        sel   = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    tid_d   = tid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    m_data  = '0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    s_ready = '0;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BURST;
          tid_d   = sel;
          cnt_d   = '0;
          for (int i = 0; i < NUM_SRC; i++)
            grant_d[i] = (sel == ID_W'(i));
        end
      end
      BURST: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant_q[i]) begin
            m_data     = bus.s_axis_tdata[i*DATA_W +: DATA_W];
            m_valid    = bus.s_axis_tvalid[i];
            s_ready[i] = bus.m_axis_tready;
          end
        end
        m_last = (cnt_q == CW'(FRAME_LEN - 1));
        fire   = m_valid && bus.m_axis_tready;
        if (fire) begin
          if (m_last) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = tid_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_axis_tdata  = m_data;
  assign bus.m_axis_tvalid = m_valid;
  assign bus.m_axis_tlast  = m_last;
  assign bus.m_axis_tid    = tid_q;
  assign bus.s_axis_tready = s_ready;
  assign grant             = grant_q;
  assign busy              = (state_q == BURST);
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed scoreboard bench for axis_frame_arbiter: expected beats are
// queued by the stimulus, a negedge monitor pops and compares them.
module tb_axis_frame_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FL = 8;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] id;
    logic          l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] grant;
  logic         busy;

  axis_frame_arbiter_if #(
    .NUM_SRC(N), .DATA_W(DW), .ID_W(IW)
  ) bus ();

  axis_frame_arbiter #(
    .NUM_SRC(N), .DATA_W(DW),
    .FRAME_LEN(FL), .ID_W(IW)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus),
    .grant(grant),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [N-1:0] en;
  logic [N-1:0] stall;
  int           lim [N];
  int           seq [N];

  beat_t exp_q[$];
  int    tl_cyc[$];
  beat_t mon_e;

  // Source i emits (i<<8)|(seq+1) until lim beats are accepted.
  always_comb begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    for (int i = 0; i < N; i++) begin
      bus.s_axis_tvalid[i] = en[i] && !stall[i]
                             && (seq[i] < lim[i]);
      bus.s_axis_tdata[i*DW +: DW] =
        DW'((i << 8) | (seq[i] + 1));
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (!rst)
        seq[i] <= 0;
      else if (bus.s_axis_tvalid[i]
               && bus.s_axis_tready[i])
        seq[i] <= seq[i] + 1;
    end
  end

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_beat: got %0h expected none",
                 bus.m_axis_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_data", 64'(bus.m_axis_tdata), 64'(mon_e.d));
        chk("beat_tid", 64'(bus.m_axis_tid), 64'(mon_e.id));
        chk("beat_last", 64'(bus.m_axis_tlast), 64'(mon_e.l));
      end
      if (bus.m_axis_tlast) tl_cyc.push_back(cyc);
    end
  end

  task automatic push_beats(int src, int first, int n,
                            bit last_on_end);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d  = DW'((src << 8) | (first + k + 1));
      b.id = IW'(src);
      b.l  = last_on_end && (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = '0;
    stall = '0;
    for (int i = 0; i < N; i++) lim[i] = 0;
    bus.m_axis_tready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_drain(string nm, int max);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) return;
    end
    checks++;
    fails++;
    $display("FAIL %s_timeout: got %0d beats left expected 0",
             nm, exp_q.size());
  endtask

  task automatic wait_busy(string nm);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) return;
    end
    checks++;
    fails++;
    $display("FAIL %s_busy_timeout: got 0 expected 1", nm);
  endtask

  task automatic wait_seq(string nm, int src, int v);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (seq[src] == v) return;
    end
    checks++;
    fails++;
    $display("FAIL %s_seq_timeout: got %0d expected %0d",
             nm, seq[src], v);
  endtask

  logic [DW-1:0] held;
  logic          held_v;

  initial begin
    en = '0;
    stall = '0;
    for (int i = 0; i < N; i++) lim[i] = 0;
    bus.m_axis_tready = 1'b1;

    // T1: reset values, single source frame
    do_reset();
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'h0);
    chk("rst_tlast", 64'(bus.m_axis_tlast), 64'h0);
    chk("rst_tid", 64'(bus.m_axis_tid), 64'h0);
    chk("rst_tdata", 64'(bus.m_axis_tdata), 64'h0);
    chk("rst_sready", 64'(bus.s_axis_tready), 64'h0);
    @(posedge clk);
    #1;
    lim[0] = 8;
    en[0] = 1'b1;
    push_beats(0, 0, 8, 1'b1);
    @(negedge clk);
    chk("t1_pre_grant", 64'(grant), 64'h0);
    @(negedge clk);
    chk("t1_grant", 64'(grant), 64'h1);
    chk("t1_busy", 64'(busy), 64'h1);
    wait_drain("t1", 40);
    chk("t1_busy_end", 64'(busy), 64'h0);

    // T2: all sources valid, rotation 0,1,2,3,0
    do_reset();
    tl_cyc.delete();
    lim[0] = 16;
    for (int i = 1; i < N; i++) lim[i] = 8;
    push_beats(0, 0, 8, 1'b1);
    push_beats(1, 0, 8, 1'b1);
    push_beats(2, 0, 8, 1'b1);
    push_beats(3, 0, 8, 1'b1);
    push_beats(0, 8, 8, 1'b1);
    en = '1;
    wait_busy("t2");
    wait_drain("t2", 120);
    chk("t2_frames", 64'(tl_cyc.size()), 64'd5);
    if (tl_cyc.size() == 5)
      for (int k = 0; k < 4; k++)
        chk("t2_period", 64'(tl_cyc[k+1] - tl_cyc[k]), 64'd9);

    // T3: last_idx=1 with sources 1 and 3 -> 3 then 1
    do_reset();
    lim[1] = 16;
    lim[3] = 8;
    push_beats(1, 0, 8, 1'b1);
    push_beats(3, 0, 8, 1'b1);
    push_beats(1, 8, 8, 1'b1);
    en[1] = 1'b1;
    wait_busy("t3");
    chk("t3_tid_first", 64'(bus.m_axis_tid), 64'd1);
    en[3] = 1'b1;
    wait_drain("t3", 80);

    // T4: granted source stalls for 5 cycles, source 2 waits
    do_reset();
    lim[0] = 8;
    lim[2] = 8;
    push_beats(0, 0, 8, 1'b1);
    push_beats(2, 0, 8, 1'b1);
    en[0] = 1'b1;
    wait_busy("t4");
    en[2] = 1'b1;
    wait_seq("t4", 0, 3);
    stall[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_grant_hold", 64'(grant), 64'h1);
      chk("t4_s2_ready", 64'(bus.s_axis_tready[2]), 64'h0);
      chk("t4_no_valid", 64'(bus.m_axis_tvalid), 64'h0);
    end
    @(posedge clk);
    #1;
    chk("t4_seq_gap", 64'(seq[0]), 64'd3);
    stall[0] = 1'b0;
    wait_drain("t4", 60);

    // T5: sampler backpressure toggling
    do_reset();
    lim[1] = 8;
    push_beats(1, 0, 8, 1'b1);
    en[1] = 1'b1;
    held_v = 1'b0;
    held = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (held_v)
        chk("t5_hold", 64'(bus.m_axis_tdata), 64'(held));
      held_v = bus.m_axis_tvalid && !bus.m_axis_tready;
      held = bus.m_axis_tdata;
      if (exp_q.size() == 0 && !busy) break;
      @(posedge clk);
      #1;
      if (busy) bus.m_axis_tready = ~bus.m_axis_tready;
    end
    chk("t5_left", 64'(exp_q.size()), 64'd0);
    bus.m_axis_tready = 1'b1;

    // T6: reset mid-frame, then source 0 first
    do_reset();
    lim[2] = 8;
    push_beats(2, 0, 4, 1'b0);
    en[2] = 1'b1;
    wait_seq("t6", 2, 4);
    rst = 1'b0;
    bus.m_axis_tready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'h0);
    chk("t6_grant", 64'(grant), 64'h0);
    chk("t6_tvalid", 64'(bus.m_axis_tvalid), 64'h0);
    chk("t6_tlast", 64'(bus.m_axis_tlast), 64'h0);
    chk("t6_tid", 64'(bus.m_axis_tid), 64'h0);
    chk("t6_tdata", 64'(bus.m_axis_tdata), 64'h0);
    chk("t6_sready", 64'(bus.s_axis_tready), 64'h0);
    chk("t6_q_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < N; i++) push_beats(i, 0, 8, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) lim[i] = 8;
    en = '1;
    rst = 1'b1;
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    chk("t6_idle_after", 64'(grant), 64'h0);
    @(negedge clk);
    chk("t6_first_grant", 64'(grant), 64'h1);
    chk("t6_first_tid", 64'(bus.m_axis_tid), 64'd0);
    wait_drain("t6", 100);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
